// File: rtl/dnn_weight_streamer.sv
// Streams weight rows from a ready/valid source into a layer-selected DNN weight array.
// Optional macro WS_LANE_MASK_EN zeroes lanes beyond each layer's nerve count.
module dnn_weight_streamer #(
  parameter int     NumLayers    = 2,
  parameter int     MaxNumNerves = 5,
  parameter int     M_W_BitSize  = 4,
  parameter integer LNI [NumLayers-1:0] = '{5, 4},
  parameter integer LNN [NumLayers-1:0] = '{2, 5}
) (
  input  logic                                      clk,
  input  logic                                      res,
  input  logic                                      in_start,
  input  logic                                      s_valid,
  input  logic [MaxNumNerves-1:0][M_W_BitSize-1:0]  s_data,
  output logic                                      s_ready,
  input  logic                                      in_ready,
  output logic [MaxNumNerves-1:0][M_W_BitSize-1:0]  out_weights,
  output logic                                      out_valid,
  output logic [NumLayers-1:0]                      out_layer_sel,
  output logic [NumLayers-1:0]                      out_layer_release,
  output logic                                      out_busy,
  output logic                                      out_done
);

  function automatic integer max_rows();
    integer m;
    m = 1;
    for (int i = 0; i < NumLayers; i++) begin
      if (LNI[i] > m) m = LNI[i];
    end
    return m;
  endfunction

  localparam integer MaxRows = max_rows();
  localparam int     RowW    = (MaxRows > 1) ? $clog2(MaxRows) : 1;
  localparam int     LayerW  = (NumLayers > 1) ? $clog2(NumLayers) : 1;

`ifdef WS_LANE_MASK_EN
  localparam bit MaskEn = 1'b1;
`else
  localparam bit MaskEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, RELEASE, DONE} state_t;

  state_t              state, state_next;
  logic [LayerW-1:0]   k, k_next;
  logic [RowW-1:0]     r, r_next;
  logic [RowW-1:0]     last_row;
  int                  lane_limit;
  logic                handshake;
  logic [MaxNumNerves-1:0][M_W_BitSize-1:0] row_data;

  assign s_ready   = (state == LOAD) && in_ready;
  assign handshake = s_ready && s_valid;
  assign out_busy  = (state == LOAD) || (state == RELEASE);
  assign out_done  = (state == DONE);

  // Per-layer geometry selected by the current layer counter.
  always_comb begin
    last_row   = '0;
    lane_limit = MaxNumNerves;
    for (int i = 0; i < NumLayers; i++) begin
      if (k == LayerW'(i)) begin
        last_row   = RowW'(LNI[i] - 1);
        lane_limit = LNN[i];
      end
    end
  end

  always_comb begin
    row_data = s_data;
    for (int lane = 0; lane < MaxNumNerves; lane++) begin
      if (MaskEn && (lane >= lane_limit)) row_data[lane] = '0;
    end
  end

  always_comb begin
    out_layer_sel     = '0;
    out_layer_release = '0;
    if (out_busy)          out_layer_sel[k]     = 1'b1;
    if (state == RELEASE)  out_layer_release[k] = 1'b1;
  end

  always_comb begin
    state_next = state;
    k_next     = k;
    r_next     = r;
    case (state)
      IDLE: begin
        if (in_start) begin
          state_next = LOAD;
          k_next     = '0;
          r_next     = '0;
        end
      end
      LOAD: begin
        if (handshake) begin
          if (r == last_row) begin
            r_next     = '0;
            state_next = RELEASE;
          end else begin
            r_next = r + RowW'(1);
          end
        end
      end
      RELEASE: begin
        if (k == LayerW'(NumLayers - 1)) begin
          state_next = DONE;
        end else begin
          k_next     = k + LayerW'(1);
          state_next = LOAD;
        end
      end
      DONE: begin
        // A start request seen here is deliberately dropped.
        state_next = IDLE;
        k_next     = '0;
        r_next     = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state       <= IDLE;
      k           <= '0;
      r           <= '0;
      out_weights <= '0;
      out_valid   <= 1'b0;
    end else begin
      state     <= state_next;
      k         <= k_next;
      r         <= r_next;
      out_valid <= handshake;
      if (handshake) out_weights <= row_data;
    end
  end

endmodule

// File: tb/tb_dnn_weight_streamer.sv
// Directed, table-driven bench for dnn_weight_streamer at default parameters.
// Lane-mask expectations follow WS_LANE_MASK_EN when it is defined for the build.
module tb_dnn_weight_streamer;

  localparam int NL = 2;
  localparam int NN = 5;
  localparam int BW = 4;
  localparam int DW = NN * BW;

  logic                  clk = 1'b0;
  logic                  res;
  logic                  in_start, s_valid, s_ready, in_ready;
  logic [NN-1:0][BW-1:0] s_data, out_weights;
  logic                  out_valid, out_busy, out_done;
  logic [NL-1:0]         out_layer_sel, out_layer_release;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          start;
    logic          valid;
    logic          rdy;
    logic [DW-1:0] data;
    logic          exp_sready;
    logic          exp_valid;
    logic [DW-1:0] exp_w;
    logic [NL-1:0] exp_sel;
    logic [NL-1:0] exp_rel;
    logic          exp_busy;
    logic          exp_done;
  } vec_t;

  vec_t vecs [15];

  dnn_weight_streamer dut (
    .clk               (clk),
    .res               (res),
    .in_start          (in_start),
    .s_valid           (s_valid),
    .s_data            (s_data),
    .s_ready           (s_ready),
    .in_ready          (in_ready),
    .out_weights       (out_weights),
    .out_valid         (out_valid),
    .out_layer_sel     (out_layer_sel),
    .out_layer_release (out_layer_release),
    .out_busy          (out_busy),
    .out_done          (out_done)
  );

  always #5 clk = ~clk;

  // Layer 1 has two nerves, so only lanes 0-1 survive when masking is built in.
  function automatic logic [DW-1:0] mask_l1(input logic [DW-1:0] d);
`ifdef WS_LANE_MASK_EN
    return d & 20'h000FF;
`else
    return d;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic v, input logic rd, input logic [DW-1:0] d);
    in_start = st;
    s_valid  = v;
    in_ready = rd;
    s_data   = d;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    res = 1'b1;
    #2;
    res = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int rows;
    int done_cnt;
    int done_at;
    logic [27:0] act_v, exp_v;

    // in_start stays high through the run and the DONE cycle; IDLE afterwards proves it was ignored.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 20'h00000, 1'b0, 1'b0, 20'h00000, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 20'hA1B2C, 1'b1, 1'b0, 20'h00000, 2'b01, 2'b00, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 20'h3D4E5, 1'b1, 1'b1, 20'hA1B2C, 2'b01, 2'b00, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 20'hF6071, 1'b1, 1'b1, 20'h3D4E5, 2'b01, 2'b00, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 20'h82934, 1'b1, 1'b1, 20'hF6071, 2'b01, 2'b00, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 20'h55555, 1'b0, 1'b1, 20'h82934, 2'b01, 2'b01, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 20'hFFFFF, 1'b1, 1'b0, 20'h00000, 2'b10, 2'b00, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 20'h5A5A5, 1'b1, 1'b1, mask_l1(20'hFFFFF), 2'b10, 2'b00, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 20'h12345, 1'b1, 1'b1, mask_l1(20'h5A5A5), 2'b10, 2'b00, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 20'h6789A, 1'b1, 1'b1, mask_l1(20'h12345), 2'b10, 2'b00, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 20'hBCDEF, 1'b1, 1'b1, mask_l1(20'h6789A), 2'b10, 2'b00, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 20'h77777, 1'b0, 1'b1, mask_l1(20'hBCDEF), 2'b10, 2'b10, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 20'h88888, 1'b0, 1'b0, 20'h00000, 2'b00, 2'b00, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 20'h99999, 1'b0, 1'b0, 20'h00000, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 20'hAAAAA, 1'b0, 1'b0, 20'h00000, 2'b00, 2'b00, 1'b0, 1'b0};

    res = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    #1;
    checkOutput("reset_state",
                {s_ready, out_valid, out_weights, out_layer_sel, out_layer_release, out_busy, out_done}, 64'h0);
    @(negedge clk);
    res = 1'b0;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].start, vecs[i].valid, vecs[i].rdy, vecs[i].data);
      #1;
      act_v = {s_ready, out_valid, (vecs[i].exp_valid ? out_weights : DW'(0)),
               out_layer_sel, out_layer_release, out_busy, out_done};
      exp_v = {vecs[i].exp_sready, vecs[i].exp_valid, vecs[i].exp_w,
               vecs[i].exp_sel, vecs[i].exp_rel, vecs[i].exp_busy, vecs[i].exp_done};
      checkOutput($sformatf("vec%0d", i), act_v, exp_v);
      @(negedge clk);
    end

    // in_ready toggling during layer 0: rows only move on the high phases.
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    @(negedge clk);
    rows = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, 1'b1, (c % 2 == 0), DW'(c + 1));
      #1;
      checkOutput($sformatf("toggle_sready_c%0d", c), s_ready, (c < 7) ? (c % 2 == 0) : 0);
      checkOutput($sformatf("toggle_valid_c%0d", c), out_valid, (c % 2 == 1));
      if (out_valid && out_layer_sel == 2'b01) rows++;
      if (c == 7) begin
        checkOutput("toggle_release", out_layer_release, 2'b01);
        checkOutput("toggle_rows", rows, 4);
        checkOutput("toggle_last_row", out_weights, 20'h00007);
      end
      @(negedge clk);
    end
    doReset();

    // Reset in the middle of layer 0, then restart from row 0.
    applyStimulus(1'b1, 1'b0, 1'b1, '0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 20'h11111);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 20'h22222);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 20'h33333);
    #1;
    checkOutput("midrst_pre", {out_valid, out_weights}, {1'b1, 20'h22222});
    res = 1'b1;
    #1;
    checkOutput("midrst_outputs",
                {s_ready, out_valid, out_weights, out_layer_sel, out_layer_release, out_busy, out_done}, 64'h0);
    @(negedge clk);
    res = 1'b0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 20'h44444);
      #1;
      checkOutput($sformatf("postrst_idle_c%0d", c), {s_ready, out_valid, out_busy}, 3'b000);
      @(negedge clk);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 20'h44444);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, DW'(c + 256));
      #1;
      checkOutput($sformatf("restart_c%0d", c), {out_layer_sel, out_layer_release},
                  {2'b01, (c == 4) ? 2'b01 : 2'b00});
      if (c == 4) checkOutput("restart_last_row", out_weights, DW'(259));
      @(negedge clk);
    end
    doReset();

    // in_start pulsed during layer 1 must not restart the sequence.
    applyStimulus(1'b1, 1'b1, 1'b1, 20'h0F0F0);
    @(negedge clk);
    done_cnt = 0;
    done_at  = -1;
    for (int c = 0; c < 16; c++) begin
      applyStimulus((c == 7), 1'b1, 1'b1, 20'h0F0F0);
      #1;
      if (c == 10) checkOutput("restart_ignored_rel", out_layer_release, 2'b10);
      if (out_done) begin
        done_cnt++;
        done_at = c;
      end
      @(negedge clk);
    end
    checkOutput("single_done_count", done_cnt, 1);
    checkOutput("single_done_cycle", done_at, 11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dnn_weight_streamer.md
DNN_WEIGHT_STREAMER -- requirements
Module: dnn_weight_streamer

Interface
REQ-001 SHALL have parameter NumLayers, default 2, number of fully-connected layers to load.
REQ-002 SHALL have parameter MaxNumNerves, default 5, number of weight lanes per row.
REQ-003 SHALL have parameter M_W_BitSize, default 4, bits per weight lane.
REQ-004 SHALL have parameter integer LNI[NumLayers-1:0], default '{5, 4}, rows (inputs) per layer; index 0 is the first layer.
REQ-005 SHALL have parameter integer LNN[NumLayers-1:0], default '{2, 5}, nerves (valid lanes) per layer.
REQ-006 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-007 SHALL have port res, input, 1; reset is asynchronous and active-high.
REQ-008 SHALL have port in_start, input, 1, begin a load sequence from IDLE.
REQ-009 SHALL have port s_valid, input, 1, source row available.
REQ-010 SHALL have port s_data, input, [MaxNumNerves-1:0][M_W_BitSize-1:0], source weight row.
REQ-011 SHALL have port s_ready, output, 1, row accepted when s_valid && s_ready.
REQ-012 SHALL have port in_ready, input, 1, downstream array can take a row.
REQ-013 SHALL have port out_weights, output, [MaxNumNerves-1:0][M_W_BitSize-1:0], registered weight row.
REQ-014 SHALL have port out_valid, output, 1, out_weights valid this cycle.
REQ-015 SHALL have port out_layer_sel, output, [NumLayers-1:0], one-hot layer being loaded; 0 when idle.
REQ-016 SHALL have port out_layer_release, output, [NumLayers-1:0], one-cycle pulse when a layer's last row is delivered.
REQ-017 SHALL have port out_busy, output, 1, high in LOAD or RELEASE.
REQ-018 SHALL have port out_done, output, 1, one-cycle pulse after final layer released.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, RELEASE, DONE.
REQ-020 IDLE -> LOAD when in_start=1; layer counter k=0, row counter r=0.
REQ-021 SHALL drive s_ready = (state==LOAD) && in_ready, combinationally; 0 in all other states.
REQ-022 On handshake in LOAD: out_weights <= s_data, out_valid <= 1 next cycle (latency 1), r increments; otherwise out_valid <= 0.
REQ-023 On handshake with r == LNI[k]-1: r <= 0, go to RELEASE.
REQ-024 RELEASE lasts exactly one cycle with out_layer_release[k]=1 and s_ready=0; then k<NumLayers-1 -> LOAD with k+1, else -> DONE.
REQ-025 DONE lasts one cycle with out_done=1, then -> IDLE.
REQ-026 out_layer_sel SHALL be one-hot bit k in LOAD and RELEASE, and SHALL stay aligned with out_valid (bit of the row's layer).
REQ-027 in_start while not IDLE SHALL be ignored; in_start in DONE cycle SHALL NOT start a new sequence.
REQ-028 s_valid=1 with in_ready=0 SHALL stall: no row consumed, counters hold, out_valid=0.
REQ-029 Counters SHALL be sized $clog2 of max(LNI) and NumLayers, never wrap within a layer.

Reset
REQ-030 Asserting res at any time, including mid-LOAD, SHALL immediately force IDLE, k=0, r=0 and all outputs to 0 (out_weights=0).
REQ-031 After res deasserts, no row SHALL be consumed until a new in_start.

Configuration
REQ-032 With macro WS_LANE_MASK_EN defined, lanes >= LNN[k] of out_weights SHALL be forced to 0; without it, s_data SHALL pass unmodified.

Verification
REQ-033 Defaults, in_start, s_valid and in_ready held 1 -> 4 rows with sel=01, release[0] pulse, 5 rows with sel=10, release[1] pulse, out_done pulse; total 12 cycles from start to done.
REQ-034 in_ready toggled 1/0 each cycle during layer 0 -> s_ready follows, exactly 4 rows delivered, release[0] after 4th row.
REQ-035 res asserted after 2 rows of layer 0 -> outputs 0 same cycle; next in_start restarts at layer 0 row 0.
REQ-036 in_start pulsed during LOAD of layer 1 -> ignored; single out_done only.
REQ-037 WS_LANE_MASK_EN defined, layer 1 row s_data all lanes 4'hF -> out_weights lanes 0-1 = F, lanes 2-4 = 0; undefined -> all lanes F.
